// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block: counting mode and counter direction.
package pwm_pkg;

    typedef enum logic {
        EDGE   = 1'b0,
        CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Control/status bundle between the command decoder (master) and pwm_multi (slave).
// load is a one-cycle strobe sampled on the rising clock edge; there is no ready/back-pressure.
interface pwm_multi_if #(
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16
);
    import pwm_pkg::*;

    logic                      en;
    logic                      load;
    logic [CNT_W-1:0]          period;
    logic [CHANNELS*CNT_W-1:0] duty;
    pwm_mode_e                 mode;

    logic [CHANNELS-1:0]       pwm_out;
    logic                      period_start;
    logic                      pending;
    // Counter state, exposed for observation only
    logic [CNT_W-1:0]          dbg_cnt;
    pwm_dir_e                  dbg_dir;

    modport master (
        output en, load, period, duty, mode,
        input  pwm_out, period_start, pending, dbg_cnt, dbg_dir
    );

    modport slave (
        input  en, load, period, duty, mode,
        output pwm_out, period_start, pending, dbg_cnt, dbg_dir
    );

endinterface

// File: rtl/pwm_compare.sv
// One PWM channel: active duty register, compare against the shared counter, invert, register.
module pwm_compare #(
    parameter int   CNT_W = 16,
    parameter logic INV   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             duty_we,
    input  logic [CNT_W-1:0] duty_in,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);

    logic [CNT_W-1:0] duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty <= '0;
            pwm  <= INV;
        end else begin
            if (duty_we) begin
                duty <= duty_in;
            end
            // cnt never exceeds P-1, so duty >= P stays active straight through the wrap
            pwm <= (run && (cnt < duty)) ^ INV;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned counter, double-buffered period/duty/mode
// applied only at period boundaries (or immediately while disabled).
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                  CHANNELS = 2,
    parameter int                  CNT_W    = 16,
    parameter logic [CHANNELS-1:0] INV_MASK = '0
) (
    input logic        clk,
    input logic        rst,
    pwm_multi_if.slave bus
);

    logic [CNT_W-1:0]          cnt;
    pwm_dir_e                  dir;
    logic [CNT_W-1:0]          act_period;
    pwm_mode_e                 act_mode;
    logic [CNT_W-1:0]          pend_period;
    logic [CHANNELS*CNT_W-1:0] pend_duty;
    pwm_mode_e                 pend_mode;
    logic                      pending;
    logic                      period_start;

    logic [CNT_W-1:0]          last_val;
    logic                      run;
    logic                      wrap;
    logic                      apply;
    logic                      upd;
    logic [CHANNELS*CNT_W-1:0] new_duty;
    logic [CHANNELS-1:0]       pwm_bits;

    assign last_val = act_period - CNT_W'(1);
    assign run      = bus.en && (act_period != '0);

    // With no active period there is no boundary to wait for, so every cycle counts as one.
    always_comb begin
        wrap = 1'b0;
        if (bus.en) begin
            if (act_period == '0) begin
                wrap = 1'b1;
            end else if (act_mode == EDGE) begin
                wrap = (cnt == last_val);
            end else begin
                wrap = (dir == DOWN) && (cnt == '0);
            end
        end
    end

    assign apply    = !bus.en || wrap;
    assign upd      = apply && (bus.load || pending);
    assign new_duty = bus.load ? bus.duty : pend_duty;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            dir          <= UP;
            act_period   <= '0;
            act_mode     <= EDGE;
            pend_period  <= '0;
            pend_duty    <= '0;
            pend_mode    <= EDGE;
            pending      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            period_start <= run && (cnt == '0) && (dir == UP);
            if (apply) begin
                cnt     <= '0;
                dir     <= UP;
                pending <= 1'b0;
                // A load arriving on the boundary itself bypasses the shadow registers
                if (bus.load) begin
                    act_period <= bus.period;
                    act_mode   <= bus.mode;
                end else if (pending) begin
                    act_period <= pend_period;
                    act_mode   <= pend_mode;
                end
            end else begin
                if (bus.load) begin
                    pend_period <= bus.period;
                    pend_duty   <= bus.duty;
                    pend_mode   <= bus.mode;
                    pending     <= 1'b1;
                end
                if (act_mode == EDGE) begin
                    cnt <= cnt + CNT_W'(1);
                end else if (dir == UP) begin
                    // Top value is held one extra cycle while turning around
                    if (cnt == last_val) begin
                        dir <= DOWN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        pwm_compare #(
            .CNT_W (CNT_W),
            .INV   (INV_MASK[i])
        ) u_cmp (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .duty_we (upd),
            .duty_in (new_duty[i*CNT_W +: CNT_W]),
            .cnt     (cnt),
            .pwm     (pwm_bits[i])
        );
    end

    assign bus.pwm_out      = pwm_bits;
    assign bus.period_start = period_start;
    assign bus.pending      = pending;
    assign bus.dbg_cnt      = cnt;
    assign bus.dbg_dir      = dir;

endmodule
